// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types, defaults and helpers for the memory_map bus arbiter.
package bus_arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_e;

   localparam int unsigned BUS_ADDR_W  = 32;
   localparam int unsigned BUS_DATA_W  = 32;
   localparam int unsigned BUS_BE_W    = BUS_DATA_W / 8;
   localparam int unsigned MAX_MASTERS = 8;
   localparam int unsigned ID_W        = $clog2(MAX_MASTERS);

   typedef logic [BUS_ADDR_W-1:0] addr_t;
   typedef logic [BUS_DATA_W-1:0] data_t;
   typedef logic [BUS_BE_W-1:0]   be_t;
   typedef logic [ID_W-1:0]       master_id_t;

   typedef struct packed {
      logic       vld;
      master_id_t id;
   } rd_slot_t;

   function automatic master_id_t next_id(input master_id_t id, input int unsigned n);
      return ((32'(id) + 32'd1) >= n) ? '0 : master_id_t'(id + 1'b1);
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational priority picker; fixed mode searches from index 0,
// round-robin mode searches from the start pointer with wrap-around.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS = 2
) (
   input  logic [N_MASTERS-1:0] req,
   input  master_id_t           start,
   input  arb_mode_e            mode,
   output master_id_t           winner,
   output logic                 found
);

   master_id_t base;

   always_comb begin
      base   = (mode == ARB_RR) ? start : '0;
      winner = '0;
      found  = 1'b0;
      // First pass covers [base, N), second pass wraps around to [0, base).
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (!found && req[i] && (master_id_t'(i) >= base)) begin
            winner = master_id_t'(i);
            found  = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (!found && req[i]) begin
            winner = master_id_t'(i);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master to single-slave memory_map bus arbiter with registered grant,
// lock and routed read returns. Optional lock timeout enabled by BUS_ARB_TIMEOUT_EN.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned  N_MASTERS    = 2,
   parameter int unsigned  ADDR_W       = BUS_ADDR_W,
   parameter int unsigned  DATA_W       = BUS_DATA_W,
   parameter arb_mode_e    ARB_MODE     = ARB_FIXED,
   parameter int unsigned  READ_LATENCY = 1,
   parameter int unsigned  MAX_HOLD     = 256,
   localparam int unsigned BE_W         = DATA_W / 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_MASTERS-1:0]        m_req,
   input  logic [N_MASTERS-1:0]        m_lock,
   input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
   input  logic [N_MASTERS*BE_W-1:0]   m_we,
   output logic [N_MASTERS-1:0]        m_gnt,
   output logic [N_MASTERS-1:0]        m_rvalid,
   output logic [DATA_W-1:0]           m_rdata,
   output logic [ADDR_W-1:0]           s_addr,
   output logic [DATA_W-1:0]           s_wdata,
   output logic [BE_W-1:0]             s_we,
   input  logic [DATA_W-1:0]           s_rdata,
   output logic                        o_timeout
);

   if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS || READ_LATENCY < 1 ||
       READ_LATENCY > 4 || MAX_HOLD < 1) begin : g_bad_cfg
      $error("bus_arbiter: unsupported parameter set");
   end

   arb_state_e           state;
   master_id_t           owner;
   master_id_t           rr_ptr;
   logic [N_MASTERS-1:0] own_mask;
   logic [N_MASTERS-1:0] pick_req;
   logic [N_MASTERS-1:0] gnt_next;
   master_id_t           pick_id;
   logic                 pick_found;
   logic                 owner_req;
   logic                 owner_lock;
   logic                 owner_rd;
   logic                 hold_hit;
   logic                 switch_en;
   logic                 go_idle;
   logic [BE_W-1:0]      owner_we;
   rd_slot_t             rd_pipe [READ_LATENCY];

   always_comb begin
      own_mask = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         own_mask[i] = (state == ST_OWNED) && (owner == master_id_t'(i));
      end
   end

   always_comb begin
      s_addr   = '0;
      s_wdata  = '0;
      owner_we = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (own_mask[i]) begin
            s_addr   = m_addr[i*ADDR_W +: ADDR_W];
            s_wdata  = m_wdata[i*DATA_W +: DATA_W];
            owner_we = m_we[i*BE_W +: BE_W];
         end
      end
   end

   assign s_we       = owner_we;
   assign m_rdata    = s_rdata;
   assign owner_req  = |(m_req & own_mask);
   assign owner_lock = |(m_lock & own_mask);
   assign owner_rd   = owner_req && (owner_we == '0);
   // The owner is masked out, so in RR the search from rr_ptr (= owner+1) finds the next requester after it.
   assign pick_req   = m_req & ~own_mask;

   rr_pick #(
      .N_MASTERS(N_MASTERS)
   ) u_pick (
      .req   (pick_req),
      .start (rr_ptr),
      .mode  (ARB_MODE),
      .winner(pick_id),
      .found (pick_found)
   );

   always_comb begin
      gnt_next = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         gnt_next[i] = (pick_id == master_id_t'(i));
      end
   end

   always_comb begin
      switch_en = 1'b0;
      go_idle   = 1'b0;
      if (state == ST_IDLE) begin
         switch_en = pick_found;
      end else if (!owner_req) begin
         switch_en = pick_found;
         go_idle   = !pick_found;
      end else if (!(owner_lock && !hold_hit) && pick_found) begin
         switch_en = (ARB_MODE == ARB_RR) || (pick_id < owner);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         owner  <= '0;
         rr_ptr <= '0;
         m_gnt  <= '0;
      end else if (switch_en) begin
         state  <= ST_OWNED;
         owner  <= pick_id;
         rr_ptr <= next_id(pick_id, N_MASTERS);
         m_gnt  <= gnt_next;
      end else if (go_idle) begin
         state  <= ST_IDLE;
         m_gnt  <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            rd_pipe[i] <= '0;
         end
      end else begin
         rd_pipe[0] <= '{vld: owner_rd, id: owner};
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
      end
   end

   always_comb begin
      m_rvalid = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         m_rvalid[i] = rd_pipe[READ_LATENCY-1].vld &&
                       (rd_pipe[READ_LATENCY-1].id == master_id_t'(i));
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              owner_held;

   assign owner_held = owner_req && owner_lock;
   // Counter saturates one below MAX_HOLD so an unrevoked owner keeps reporting the hit.
   assign hold_hit   = owner_held && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt  <= '0;
         o_timeout <= 1'b0;
      end else begin
         if (switch_en || go_idle || !owner_held) begin
            hold_cnt <= '0;
         end else if (!hold_hit) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
         if (hold_hit) begin
            o_timeout <= 1'b1;
         end
      end
   end
`else
   assign hold_hit  = 1'b0;
   assign o_timeout = 1'b0;
`endif

endmodule
